// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch-request controller for the IF stage.
// Holds a pending-redirect latch so branches resolved while fetch cannot advance are kept.
module pc_fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_0000,
    parameter int unsigned          PC_INC   = 4,
    parameter int unsigned          STALL_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   new_pc,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    input  logic                ibus_ack,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                pend_valid_o,
    output logic                pc_misalign_o
);

    localparam logic [0:0] ST_RESET = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              in_run_s;
    logic              advance_s;

    assign in_run_s  = (state_q == ST_RUN);
    assign advance_s = in_run_s & ibus_ack & ~stall[0];

    // State machine: leaves RESET on the first edge without rst and never returns except via rst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // Next pc and pending latch; flush beats branch beats pending beats increment.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (flush) begin
            pc_d         = new_pc;
            pend_valid_d = 1'b0;
        end else if (advance_s && branch_flag_i) begin
            pc_d         = branch_target_address_i;
            pend_valid_d = 1'b0;
        end else if (advance_s && pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else if (advance_s) begin
            pc_d = pc_q + PC_STEP;
        end else if (in_run_s && branch_flag_i) begin
            // Fetch cannot move this cycle: remember the redirect, newest branch wins.
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target_address_i;
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RESET;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc            = pc_q;
    assign ce            = in_run_s;
    assign pend_valid_o  = pend_valid_q;
    assign pc_misalign_o = in_run_s & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with hand-computed expected values.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_ack;
    logic [31:0] pc;
    logic        ce;
    logic        pend_valid_o;
    logic        pc_misalign_o;

    int total;
    int bad;

    pc_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4),
        .STALL_W  (6)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_ack                (ibus_ack),
        .pc                      (pc),
        .ce                      (ce),
        .pend_valid_o            (pend_valid_o),
        .pc_misalign_o           (pc_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'd0;
        branch_flag_i = 1'b0; branch_target_address_i = 32'd0; ibus_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++; if (pc !== 32'h0 || ce !== 1'b0) begin bad++; $display("FAIL reset_hold pc=%h ce=%b want pc=0 ce=0", pc, ce); end
        total++; if (pend_valid_o !== 1'b0 || pc_misalign_o !== 1'b0) begin bad++; $display("FAIL reset_flags pend=%b mis=%b want 0 0", pend_valid_o, pc_misalign_o); end
        rst = 1'b0;
        step();
        total++; if (pc !== 32'h0 || ce !== 1'b1) begin bad++; $display("FAIL release pc=%h ce=%b want pc=0 ce=1", pc, ce); end
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (pc !== 32'(i * 4)) begin bad++; $display("FAIL seq pc=%h want %h", pc, 32'(i * 4)); end
        end
    endtask

    task automatic test_stall_wait();
        stall = 6'b000001;
        step(); step();
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL stall_hold pc=%h want 00000010", pc); end
        stall = 6'b111110; ibus_ack = 1'b0;
        step(); step();
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL wait_hold pc=%h want 00000010", pc); end
        ibus_ack = 1'b1;
        step();
        total++; if (pc !== 32'h14) begin bad++; $display("FAIL wait_release pc=%h want 00000014", pc); end
        stall = 6'd0;
        step(); step(); step();
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL upper_stall_ignored pc=%h want 00000020", pc); end
    endtask

    task automatic test_branch_during_stall();
        stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        step();
        total++; if (pc !== 32'h20 || pend_valid_o !== 1'b1) begin bad++; $display("FAIL br_stall_latch pc=%h pend=%b want 00000020 1", pc, pend_valid_o); end
        branch_flag_i = 1'b0; branch_target_address_i = 32'h200;
        step();
        total++; if (pc !== 32'h20 || pend_valid_o !== 1'b1) begin bad++; $display("FAIL br_stall_hold pc=%h pend=%b want 00000020 1", pc, pend_valid_o); end
        stall = 6'd0;
        step();
        total++; if (pc !== 32'h100 || pend_valid_o !== 1'b0) begin bad++; $display("FAIL br_stall_issue pc=%h pend=%b want 00000100 0", pc, pend_valid_o); end
    endtask

    task automatic test_overwrite_priority();
        ibus_ack = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        step();
        branch_target_address_i = 32'h400;
        step();
        total++; if (pc !== 32'h100 || pend_valid_o !== 1'b1) begin bad++; $display("FAIL ovw_pending pc=%h pend=%b want 00000100 1", pc, pend_valid_o); end
        branch_flag_i = 1'b0; ibus_ack = 1'b1;
        step();
        total++; if (pc !== 32'h400 || pend_valid_o !== 1'b0) begin bad++; $display("FAIL ovw_newest pc=%h pend=%b want 00000400 0", pc, pend_valid_o); end
        ibus_ack = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        step();
        branch_target_address_i = 32'h400;
        step();
        ibus_ack = 1'b1; branch_target_address_i = 32'h500;
        step();
        total++; if (pc !== 32'h500 || pend_valid_o !== 1'b0) begin bad++; $display("FAIL live_branch_wins pc=%h pend=%b want 00000500 0", pc, pend_valid_o); end
        branch_flag_i = 1'b0;
        step();
        total++; if (pc !== 32'h504) begin bad++; $display("FAIL after_branch pc=%h want 00000504", pc); end
    endtask

    task automatic test_flush_priority();
        stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h600;
        step();
        total++; if (pend_valid_o !== 1'b1) begin bad++; $display("FAIL flush_setup pend=%b want 1", pend_valid_o); end
        branch_target_address_i = 32'h80; flush = 1'b1; new_pc = 32'h40;
        step();
        total++; if (pc !== 32'h40 || pend_valid_o !== 1'b0) begin bad++; $display("FAIL flush_wins pc=%h pend=%b want 00000040 0", pc, pend_valid_o); end
        flush = 1'b0; branch_flag_i = 1'b0; stall = 6'd0;
        step();
        total++; if (pc !== 32'h44) begin bad++; $display("FAIL flush_then_inc pc=%h want 00000044", pc); end
    endtask

    task automatic test_wrap_misalign();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        step();
        total++; if (pc !== 32'hFFFF_FFFC || pc_misalign_o !== 1'b0) begin bad++; $display("FAIL wrap_load pc=%h mis=%b want fffffffc 0", pc, pc_misalign_o); end
        flush = 1'b0;
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap pc=%h want 00000000", pc); end
        flush = 1'b1; new_pc = 32'h102;
        step();
        total++; if (pc !== 32'h102 || pc_misalign_o !== 1'b1) begin bad++; $display("FAIL misalign_load pc=%h mis=%b want 00000102 1", pc, pc_misalign_o); end
        flush = 1'b0;
        step();
        total++; if (pc !== 32'h106 || pc_misalign_o !== 1'b1) begin bad++; $display("FAIL misalign_inc pc=%h mis=%b want 00000106 1", pc, pc_misalign_o); end
        rst = 1'b1;
        step();
        total++; if (pc !== 32'h0 || ce !== 1'b0 || pc_misalign_o !== 1'b0 || pend_valid_o !== 1'b0) begin
            bad++; $display("FAIL midrun_reset pc=%h ce=%b mis=%b pend=%b want 0 0 0 0", pc, ce, pc_misalign_o, pend_valid_o); end
    endtask

    task automatic test_reset_state_inputs();
        rst = 1'b1; stall = 6'd0; ibus_ack = 1'b1;
        step();
        rst = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h700;
        step();
        total++; if (pc !== 32'h0 || pend_valid_o !== 1'b0 || ce !== 1'b1) begin
            bad++; $display("FAIL reset_branch_ignored pc=%h pend=%b ce=%b want 0 0 1", pc, pend_valid_o, ce); end
        branch_flag_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; flush = 1'b1; new_pc = 32'h800;
        step();
        total++; if (pc !== 32'h800 || ce !== 1'b1) begin bad++; $display("FAIL reset_flush pc=%h ce=%b want 00000800 1", pc, ce); end
        flush = 1'b0;
        step();
        total++; if (pc !== 32'h804) begin bad++; $display("FAIL reset_flush_inc pc=%h want 00000804", pc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stall_wait();
        test_branch_during_stall();
        test_overwrite_priority();
        test_flush_priority();
        test_wrap_misalign();
        test_reset_state_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
